// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM controller slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    localparam int PWM_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the ck domain.
// Latency: q follows d after two rising edges of ck.
// Backpressure: none; free-running level path.
module pwm_sync2 (
    input  logic ck,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; the first stage may go metastable, the second settles it.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// PWM generator with shadowed duty/period registers and a graceful stop.
// Latency: pwm_out lags cnt by one cycle; en takes two edges to be seen.
// Backpressure: a load request is held off (no load_ack) while a shadow load is pending.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int W = PWM_W_DEF
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] duty_in,
    input  logic [W-1:0] period_in,
    input  logic         load_req,
    output logic         load_ack,
    output logic         pwm_out,
    output logic [W-1:0] cnt,
    output logic         period_end,
    output logic         busy
);

    logic         en_s;
    pwm_state_t   state;
    pwm_state_t   state_nxt;
    logic [W-1:0] per_act;
    logic [W-1:0] duty_act;
    logic [W-1:0] per_sh;
    logic [W-1:0] duty_sh;
    logic         pend;
    logic         at_end;
    logic         cap;
    logic         xfer;

    pwm_sync2 u_sync (
        .ck  (ck),
        .rst (rst),
        .d   (en),
        .q   (en_s)
    );

    // Period boundary, shadow capture and shadow-to-active transfer decisions.
    // cap needs pend=0 and xfer needs pend=1, so they can never share an edge.
    assign busy       = (state != IDLE);
    assign at_end     = busy && (cnt == per_act);
    assign period_end = at_end;
    assign cap        = load_req && !pend;
    assign xfer       = pend && (!busy || at_end);

    // State register.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: STOP finishes the current period before going idle; a
    // re-raised run request in STOP resumes without restarting the period.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (en_s) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en_s) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (en_s) begin
                    state_nxt = RUN;
                end else if (at_end) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Period counter: parked at 0 while idle, wraps at the active period end.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!busy || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    // Registered waveform and acknowledge pulse.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            pwm_out  <= 1'b0;
            load_ack <= 1'b0;
        end else begin
            pwm_out  <= busy && (cnt < duty_act);
            load_ack <= cap;
        end
    end

    // Shadow registers and pending flag; the shadow is written only on capture.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            duty_sh <= '0;
            per_sh  <= '1;
            pend    <= 1'b0;
        end else if (cap) begin
            duty_sh <= duty_in;
            per_sh  <= period_in;
            pend    <= 1'b1;
        end else if (xfer) begin
            pend    <= 1'b0;
        end
    end

    // Active registers change only at a period boundary or while idle.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            duty_act <= '0;
            per_act  <= '1;
        end else if (xfer) begin
            duty_act <= duty_sh;
            per_act  <= per_sh;
        end
    end

endmodule

// File: tb/tb_pwm_ctrl.sv
module tb_pwm_ctrl;

    localparam int W = 8;

    logic         ck = 1'b0;
    logic         rst;
    logic         en;
    logic         load_req;
    logic [W-1:0] duty_in;
    logic [W-1:0] period_in;
    logic         load_ack;
    logic         pwm_out;
    logic [W-1:0] cnt;
    logic         period_end;
    logic         busy;

    int nvec = 0;
    int nmis = 0;

    pwm_ctrl #(.W(W)) dut (
        .ck         (ck),
        .rst        (rst),
        .en         (en),
        .duty_in    (duty_in),
        .period_in  (period_in),
        .load_req   (load_req),
        .load_ack   (load_ack),
        .pwm_out    (pwm_out),
        .cnt        (cnt),
        .period_end (period_end),
        .busy       (busy)
    );

    always #5 ck = ~ck;

    typedef struct {
        bit pwm;
        int cnt;
        bit pe;
        bit busy;
        bit ack;
    } exp_t;

    exp_t sb[$];

    // Reference model: "active" means a period is in progress, "draining"
    // means the run request is gone and the current period is being finished.
    bit m_act, m_drain, m_pend, m_s1, m_s2;
    int m_pos, m_duty, m_per, m_sduty, m_sper;

    always @(posedge ck) begin : model
        exp_t e;
        bit   wrap;
        bit   xfer;
        bit   ack;
        bit   p;
        if (rst) begin
            m_act = 0; m_drain = 0; m_pend = 0; m_s1 = 0; m_s2 = 0;
            m_pos = 0; m_duty = 0; m_per = 255; m_sduty = 0; m_sper = 255;
            e.pwm = 0; e.cnt = 0; e.pe = 0; e.busy = 0; e.ack = 0;
        end else begin
            ack  = load_req && !m_pend;
            p    = m_act && (m_pos < m_duty);
            wrap = m_act && (m_pos == m_per);
            xfer = m_pend && (!m_act || wrap);
            if (!m_act) begin
                m_act   = m_s2;
                m_drain = 0;
                m_pos   = 0;
            end else begin
                if (m_drain && !m_s2 && wrap) m_act = 0;
                m_drain = m_act && !m_s2;
                m_pos   = wrap ? 0 : m_pos + 1;
            end
            if (ack) begin
                m_sduty = int'(duty_in);
                m_sper  = int'(period_in);
                m_pend  = 1;
            end
            if (xfer) begin
                m_duty = m_sduty;
                m_per  = m_sper;
                m_pend = 0;
            end
            m_s2 = m_s1;
            m_s1 = en;
            e.pwm  = p;
            e.cnt  = m_pos;
            e.pe   = m_act && (m_pos == m_per);
            e.busy = m_act;
            e.ack  = ack;
        end
        sb.push_back(e);
    end

    // Monitor: compares DUT outputs shortly after each edge against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge ck);
            #2;
            nvec++;
            if (sb.size() == 0) begin
                nmis++;
                $display("FAIL sb_empty t=%0t no expected entry", $time);
            end else begin
                e = sb.pop_front();
                if (pwm_out !== e.pwm || int'(cnt) != e.cnt || period_end !== e.pe ||
                    busy !== e.busy || load_ack !== e.ack) begin
                    nmis++;
                    $display("FAIL cycle t=%0t got pwm=%0b cnt=%0d pe=%0b busy=%0b ack=%0b exp pwm=%0b cnt=%0d pe=%0b busy=%0b ack=%0b",
                             $time, pwm_out, cnt, period_end, busy, load_ack,
                             e.pwm, e.cnt, e.pe, e.busy, e.ack);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic load(input int d, input int p);
        duty_in   = W'(d);
        period_in = W'(p);
        load_req  = 1'b1;
        @(negedge ck);
        load_req  = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (int'(cnt) != v) begin
            @(negedge ck);
            n++;
            if (n > 300) begin
                nmis++;
                $display("FAIL wait_cnt got=%0d want=%0d", cnt, v);
                return;
            end
        end
    endtask

    initial begin : driver
        rst = 1'b1; en = 1'b0; load_req = 1'b0; duty_in = '0; period_in = '0;
        cyc(3);
        rst = 1'b0;
        cyc(4);

        // 3/10 waveform
        load(3, 9);
        cyc(2);
        en = 1'b1;
        cyc(25);

        // mid-period load held high: first ack at cnt=4, second after transfer
        wait_cnt(4);
        duty_in = 8'd7; period_in = 8'd9; load_req = 1'b1;
        cyc(1);
        duty_in = 8'd5;
        cyc(12);
        load_req = 1'b0;
        cyc(25);

        // boundaries
        load(0, 9);  cyc(25);
        load(12, 9); cyc(25);
        load(1, 0);  cyc(10);
        load(3, 9);  cyc(15);

        // graceful stop, then resume from STOP without period restart
        wait_cnt(2);
        en = 1'b0;
        cyc(15);
        en = 1'b1;
        cyc(5);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(15);
        en = 1'b0;
        cyc(15);

        // reset mid-period with a pending load
        en = 1'b1;
        cyc(4);
        wait_cnt(3);
        load(6, 9);
        cyc(1);
        en  = 1'b0;
        rst = 1'b1;
        #1;
        nvec++;
        if (pwm_out !== 1'b0 || load_ack !== 1'b0 || busy !== 1'b0 ||
            period_end !== 1'b0 || cnt !== '0) begin
            nmis++;
            $display("FAIL rst_async got pwm=%0b ack=%0b busy=%0b pe=%0b cnt=%0d exp all zero",
                     pwm_out, load_ack, busy, period_end, cnt);
        end
        cyc(2);
        rst = 1'b0;
        cyc(8);
        en = 1'b1;
        cyc(20);
        rst = 1'b1;
        cyc(2);
        en  = 1'b0;
        rst = 1'b0;
        cyc(2);

        // randomized phase
        load(4, 7);
        cyc(2);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) en = ~en;
            load_req  = ($urandom_range(0, 5) == 0);
            duty_in   = W'($urandom_range(0, 17));
            period_in = W'($urandom_range(0, 15));
            @(negedge ck);
        end
        load_req = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/pwm_ctrl.md
PWM_CTRL -- requirements
Module: pwm_ctrl

Interface
REQ-001 Parameter: W, default 8, bit width of the counter, duty and period values.
REQ-002 ck  input  1  clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 en  input  1  run request; asynchronous to ck; synchronized internally.
REQ-005 duty_in  input  W  requested duty: number of high cycles per period.
REQ-006 period_in  input  W  requested period: period length = period_in+1 cycles.
REQ-007 load_req  input  1  level request to load duty_in/period_in.
REQ-008 load_ack  output  1  one-cycle pulse; duty_in/period_in captured on this edge.
REQ-009 pwm_out  output  1  registered PWM waveform.
REQ-010 cnt  output  W  current period counter.
REQ-011 period_end  output  1  high while cnt == per_act in RUN or STOP.
REQ-012 busy  output  1  high when state is not IDLE.

Function
REQ-013 en SHALL pass through a 2-flop synchronizer (en_s); en_s lags en by 2 ck edges.
REQ-014 Registers: per_act/duty_act (active), per_sh/duty_sh (shadow), pend flag, state {IDLE, RUN, STOP}.
REQ-015 IDLE->RUN when en_s=1, and cnt is loaded with 0 on that edge.
REQ-016 RUN->STOP when en_s=0, and cnt keeps counting.
REQ-017 STOP->RUN when en_s=1, with no period restart.
REQ-018 STOP->IDLE on the edge where cnt == per_act; cnt returns to 0.
REQ-019 In RUN/STOP, cnt SHALL increment by 1 per edge and wrap to 0 when cnt == per_act.
REQ-020 cnt SHALL hold 0 in IDLE.
REQ-021 pwm_out(next) = (state != IDLE) && (cnt < duty_act), giving one cycle latency versus cnt.
REQ-022 Unsigned compare: duty_act=0 gives constant 0; duty_act > per_act gives constant 1.
REQ-023 per_act=0 is legal: period of 1 cycle, and period_end is constant high in RUN.
REQ-024 Capture: load_req=1 and pend=0 at an edge -> duty_sh/per_sh are loaded, pend<=1, load_ack=1 for that one cycle.
REQ-025 While pend=1, load_req SHALL be held off (no ack) until pend clears.
REQ-026 Transfer to the active registers happens at the period-end edge in RUN/STOP, or on the next edge in IDLE; shadow -> active, pend<=0.
REQ-027 Transfer and capture SHALL NOT occur on the same edge; the earliest next capture is the edge after a transfer.
REQ-028 Active values SHALL never change mid-period; the new period starts from cnt=0 using the new values.
REQ-029 load_req while IDLE SHALL still be accepted (capture, then transfer on the following edge).

Reset
REQ-030 rst=1 SHALL immediately force:
- state=IDLE, cnt=0, pwm_out=0, load_ack=0, pend=0
- duty_act=duty_sh=0
- per_act=per_sh={W{1}}
- synchronizer flops=0
REQ-031 rst asserted mid-period SHALL abort the period immediately; a pending shadow load SHALL be discarded.
REQ-032 After rst deasserts, there is no activity until en_s rises.

Structure
REQ-033 A shared package pwm_pkg SHALL hold the state enum type (IDLE, RUN, STOP) and the default W=8.
REQ-034 The synchronizer SHALL be a sub-module pwm_sync2 (two D flops with asynchronous reset, ports ck, rst, d, q).
REQ-035 All other logic SHALL be in pwm_ctrl, with no latches or combinational outputs except period_end and busy.

Verification
REQ-036 Reset, then load duty_in=3, period_in=9, then en=1 -> pwm_out high for 3 cycles and low for 7; period 10 cycles; period_end every 10th cycle.
REQ-037 Mid-period (cnt=4), load duty_in=7, period_in=9 -> load_ack pulses; current period stays 3/10; next period is 7/10; pend clears at cnt=9.
REQ-038 Second load_req while pend=1 -> no ack until the edge after the transfer.
REQ-039 Boundary values:
- duty=0 -> pwm_out stays 0
- duty=12 with period_in=9 -> pwm_out stays 1
- period_in=0 -> period_end constant 1
REQ-040 en=0 at cnt=2 (period 10) -> busy stays 1 until cnt=9, then IDLE and pwm_out=0; en re-raised in STOP -> RUN with no cnt reset.
REQ-041 rst asserted at cnt=5 with pend=1 -> outputs zero at once, with no ack and no transfer after release.
